ldst_data_port: RTL and testbench



---
 rtl/ldst_data_port.sv | 255 +++++++++++++++++++++++++
 tb/tb_ldst_data_port.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_data_port.sv
// Load/store front-end: latches one execute-stage memory operation, issues it to
// the data cache, and returns a one-cycle formatted writeback result.
module ldst_data_port #(
    parameter bit P_ALIGN_CHECK     = 1'b1,
    parameter bit P_STORE_REPLICATE = 1'b1
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iREMOVE,
    input  logic        iEXE_REQ,
    output logic        oEXE_BUSY,
    input  logic        iEXE_RW,
    input  logic [1:0]  iEXE_ORDER,
    input  logic        iEXE_SIGNED,
    input  logic [13:0] iEXE_TID,
    input  logic [1:0]  iEXE_MMUMOD,
    input  logic [31:0] iEXE_PDT,
    input  logic [31:0] iEXE_ADDR,
    input  logic [31:0] iEXE_DATA,
    input  logic [4:0]  iEXE_DEST,
    output logic        oLDST_REQ,
    input  logic        iLDST_BUSY,
    output logic [1:0]  oLDST_ORDER,
    output logic        oLDST_RW,
    output logic [31:0] oLDST_TID,
    output logic [1:0]  oLDST_MMUMOD,
    output logic [31:0] oLDST_PDT,
    output logic [31:0] oLDST_ADDR,
    output logic [31:0] oLDST_DATA,
    input  logic        iLDST_VALID,
    input  logic        iLDST_PAGEFAULT,
    input  logic [13:0] iLDST_MMU_FLAGS,
    input  logic [31:0] iLDST_DATA,
    output logic        oWB_VALID,
    output logic        oWB_RW,
    output logic [4:0]  oWB_DEST,
    output logic [1:0]  oWB_FAULT,
    output logic [13:0] oWB_MMU_FLAGS,
    output logic [31:0] oWB_DATA,
    output logic [2:0]  dbg_state
);
    // Handshakes: an exe op is taken when iEXE_REQ && !oEXE_BUSY && !iREMOVE;
    // a cache request is taken when oLDST_REQ && !iLDST_BUSY; iLDST_VALID and
    // oWB_VALID are single-cycle pulses with no back-pressure.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t state, state_next;

    logic        r_rw;
    logic [1:0]  r_order;
    logic        r_signed;
    logic [13:0] r_tid;
    logic [1:0]  r_mmumod;
    logic [31:0] r_pdt;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_dest;

    logic [1:0]  res_fault;
    logic [13:0] res_flags;
    logic [31:0] res_data;

    logic        wb_rw_q;
    logic [4:0]  wb_dest_q;
    logic [1:0]  wb_fault_q;
    logic [13:0] wb_flags_q;
    logic [31:0] wb_data_q;

    logic        accept;
    logic        misaligned;
    logic        resp_take;
    logic [31:0] store_fmt;
    logic [31:0] load_fmt;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        misaligned = 1'b0;
        if (iEXE_ORDER == 2'd3) begin
            misaligned = 1'b1;
        end else if (P_ALIGN_CHECK) begin
            if (iEXE_ORDER == 2'd1 && iEXE_ADDR[0])
                misaligned = 1'b1;
            if (iEXE_ORDER == 2'd2 && iEXE_ADDR[1:0] != 2'b00)
                misaligned = 1'b1;
        end
    end

    always_comb begin
        store_fmt = iEXE_DATA;
        if (iEXE_ORDER == 2'd0) begin
            if (P_STORE_REPLICATE) begin
                store_fmt = {4{iEXE_DATA[7:0]}};
            end else begin
                case (iEXE_ADDR[1:0])
                    2'd0:    store_fmt = {24'h0, iEXE_DATA[7:0]};
                    2'd1:    store_fmt = {16'h0, iEXE_DATA[7:0], 8'h0};
                    2'd2:    store_fmt = {8'h0, iEXE_DATA[7:0], 16'h0};
                    default: store_fmt = {iEXE_DATA[7:0], 24'h0};
                endcase
            end
        end else if (iEXE_ORDER == 2'd1) begin
            if (P_STORE_REPLICATE)
                store_fmt = {2{iEXE_DATA[15:0]}};
            else if (iEXE_ADDR[1])
                store_fmt = {iEXE_DATA[15:0], 16'h0};
            else
                store_fmt = {16'h0, iEXE_DATA[15:0]};
        end
    end

    // Load extraction uses the latched address; half loads look only at bit 1.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    load_byte = iLDST_DATA[7:0];
            2'd1:    load_byte = iLDST_DATA[15:8];
            2'd2:    load_byte = iLDST_DATA[23:16];
            default: load_byte = iLDST_DATA[31:24];
        endcase
        load_half = r_addr[1] ? iLDST_DATA[31:16] : iLDST_DATA[15:0];
        case (r_order)
            2'd0:    load_fmt = {{24{r_signed & load_byte[7]}}, load_byte};
            2'd1:    load_fmt = {{16{r_signed & load_half[15]}}, load_half};
            default: load_fmt = iLDST_DATA;
        endcase
    end

    always_comb begin
        state_next = state;
        oEXE_BUSY  = (state != S_IDLE);
        oLDST_REQ  = 1'b0;
        oWB_VALID  = 1'b0;
        accept     = 1'b0;
        resp_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (iEXE_REQ && !iREMOVE) begin
                    accept     = 1'b1;
                    state_next = misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                oLDST_REQ = 1'b1;
                if (iREMOVE)
                    state_next = S_IDLE;
                else if (!iLDST_BUSY)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (iLDST_VALID) begin
                    resp_take  = !iREMOVE;
                    state_next = iREMOVE ? S_IDLE : S_RESP;
                end else if (iREMOVE) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (iLDST_VALID)
                    state_next = S_IDLE;
            end
            S_RESP: begin
                oWB_VALID  = !iREMOVE;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_rw     <= 1'b0;
            r_order  <= 2'd0;
            r_signed <= 1'b0;
            r_tid    <= 14'h0;
            r_mmumod <= 2'd0;
            r_pdt    <= 32'h0;
            r_addr   <= 32'h0;
            r_sdata  <= 32'h0;
            r_dest   <= 5'd0;
        end else if (accept) begin
            r_rw     <= iEXE_RW;
            r_order  <= iEXE_ORDER;
            r_signed <= iEXE_SIGNED;
            r_tid    <= iEXE_TID;
            r_mmumod <= iEXE_MMUMOD;
            r_pdt    <= iEXE_PDT;
            r_addr   <= iEXE_ADDR;
            r_sdata  <= store_fmt;
            r_dest   <= iEXE_DEST;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            res_fault <= 2'b00;
            res_flags <= 14'h0;
            res_data  <= 32'h0;
        end else if (accept && misaligned) begin
            res_fault <= 2'b10;
            res_flags <= 14'h0;
            res_data  <= 32'h0;
        end else if (resp_take) begin
            res_fault <= iLDST_PAGEFAULT ? 2'b01 : 2'b00;
            res_flags <= iLDST_MMU_FLAGS;
            res_data  <= (iLDST_PAGEFAULT || !r_rw) ? 32'h0 : load_fmt;
        end
    end

    // Visible writeback fields only change on a delivered pulse, so a flushed
    // RESP leaves the previous result on the bus.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wb_rw_q    <= 1'b0;
            wb_dest_q  <= 5'd0;
            wb_fault_q <= 2'b00;
            wb_flags_q <= 14'h0;
            wb_data_q  <= 32'h0;
        end else if (oWB_VALID) begin
            wb_rw_q    <= r_rw;
            wb_dest_q  <= r_dest;
            wb_fault_q <= res_fault;
            wb_flags_q <= res_flags;
            wb_data_q  <= res_data;
        end
    end

    assign oWB_RW        = oWB_VALID ? r_rw      : wb_rw_q;
    assign oWB_DEST      = oWB_VALID ? r_dest    : wb_dest_q;
    assign oWB_FAULT     = oWB_VALID ? res_fault : wb_fault_q;
    assign oWB_MMU_FLAGS = oWB_VALID ? res_flags : wb_flags_q;
    assign oWB_DATA      = oWB_VALID ? res_data  : wb_data_q;

    assign oLDST_ORDER  = r_order;
    assign oLDST_RW     = r_rw;
    assign oLDST_TID    = {18'h0, r_tid};
    assign oLDST_MMUMOD = r_mmumod;
    assign oLDST_PDT    = r_pdt;
    assign oLDST_ADDR   = r_addr;
    assign oLDST_DATA   = r_sdata;
    assign dbg_state    = state;

endmodule

// File: tb/tb_ldst_data_port.sv
// Self-checking bench for ldst_data_port: directed scenarios plus randomized
// aligned traffic against a behavioural model; a second instance covers the
// lane-placed store / no-align-check configuration.
module tb_ldst_data_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        remove = 1'b0;
    logic        exe_req = 1'b0;
    logic        exe_rw = 1'b0;
    logic [1:0]  exe_order = 2'd0;
    logic        exe_signed = 1'b0;
    logic [13:0] exe_tid = 14'h0;
    logic [1:0]  exe_mmumod = 2'd0;
    logic [31:0] exe_pdt = 32'h0;
    logic [31:0] exe_addr = 32'h0;
    logic [31:0] exe_data = 32'h0;
    logic [4:0]  exe_dest = 5'd0;
    logic        ldst_busy = 1'b0;
    logic        ldst_valid = 1'b0;
    logic        ldst_pf = 1'b0;
    logic [13:0] ldst_flags = 14'h0;
    logic [31:0] ldst_rdata = 32'h0;

    logic        exe_busy, ldst_req, ldst_rw, wb_valid, wb_rw;
    logic [1:0]  ldst_order, ldst_mmumod, wb_fault;
    logic [31:0] ldst_tid, ldst_pdt, ldst_addr, ldst_data, wb_data;
    logic [13:0] wb_flags;
    logic [4:0]  wb_dest;
    logic [2:0]  dbg_state;

    logic        exe_busy_b, ldst_req_b, ldst_rw_b, wb_valid_b, wb_rw_b;
    logic [1:0]  ldst_order_b, ldst_mmumod_b, wb_fault_b;
    logic [31:0] ldst_tid_b, ldst_pdt_b, ldst_addr_b, ldst_data_b, wb_data_b;
    logic [13:0] wb_flags_b;
    logic [4:0]  wb_dest_b;
    logic [2:0]  dbg_state_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ldst_data_port u_dut (
        .iCLOCK(clk), .iRESET(rst), .iREMOVE(remove),
        .iEXE_REQ(exe_req), .oEXE_BUSY(exe_busy), .iEXE_RW(exe_rw),
        .iEXE_ORDER(exe_order), .iEXE_SIGNED(exe_signed), .iEXE_TID(exe_tid),
        .iEXE_MMUMOD(exe_mmumod), .iEXE_PDT(exe_pdt), .iEXE_ADDR(exe_addr),
        .iEXE_DATA(exe_data), .iEXE_DEST(exe_dest),
        .oLDST_REQ(ldst_req), .iLDST_BUSY(ldst_busy), .oLDST_ORDER(ldst_order),
        .oLDST_RW(ldst_rw), .oLDST_TID(ldst_tid), .oLDST_MMUMOD(ldst_mmumod),
        .oLDST_PDT(ldst_pdt), .oLDST_ADDR(ldst_addr), .oLDST_DATA(ldst_data),
        .iLDST_VALID(ldst_valid), .iLDST_PAGEFAULT(ldst_pf),
        .iLDST_MMU_FLAGS(ldst_flags), .iLDST_DATA(ldst_rdata),
        .oWB_VALID(wb_valid), .oWB_RW(wb_rw), .oWB_DEST(wb_dest),
        .oWB_FAULT(wb_fault), .oWB_MMU_FLAGS(wb_flags), .oWB_DATA(wb_data),
        .dbg_state(dbg_state)
    );

    ldst_data_port #(.P_ALIGN_CHECK(1'b0), .P_STORE_REPLICATE(1'b0)) u_dut_b (
        .iCLOCK(clk), .iRESET(rst), .iREMOVE(remove),
        .iEXE_REQ(exe_req), .oEXE_BUSY(exe_busy_b), .iEXE_RW(exe_rw),
        .iEXE_ORDER(exe_order), .iEXE_SIGNED(exe_signed), .iEXE_TID(exe_tid),
        .iEXE_MMUMOD(exe_mmumod), .iEXE_PDT(exe_pdt), .iEXE_ADDR(exe_addr),
        .iEXE_DATA(exe_data), .iEXE_DEST(exe_dest),
        .oLDST_REQ(ldst_req_b), .iLDST_BUSY(ldst_busy), .oLDST_ORDER(ldst_order_b),
        .oLDST_RW(ldst_rw_b), .oLDST_TID(ldst_tid_b), .oLDST_MMUMOD(ldst_mmumod_b),
        .oLDST_PDT(ldst_pdt_b), .oLDST_ADDR(ldst_addr_b), .oLDST_DATA(ldst_data_b),
        .iLDST_VALID(ldst_valid), .iLDST_PAGEFAULT(ldst_pf),
        .iLDST_MMU_FLAGS(ldst_flags), .iLDST_DATA(ldst_rdata),
        .oWB_VALID(wb_valid_b), .oWB_RW(wb_rw_b), .oWB_DEST(wb_dest_b),
        .oWB_FAULT(wb_fault_b), .oWB_MMU_FLAGS(wb_flags_b), .oWB_DATA(wb_data_b),
        .dbg_state(dbg_state_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [1:0] order, input logic sgn,
                                           input logic [31:0] addr, input logic [31:0] d);
        int unsigned width, sh, v, mask;
        if (order == 2'd2) return d;
        width = (order == 2'd0) ? 8 : 16;
        sh    = (order == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask  = (32'd1 << width) - 1;
        v     = (d >> sh) & mask;
        if (sgn && ((v >> (width - 1)) & 1) == 1) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [1:0] order, input logic [31:0] addr,
                                            input logic [31:0] d, input bit replicate);
        int unsigned sh, mask;
        if (order == 2'd2) return d;
        mask = (order == 2'd0) ? 32'hFF : 32'hFFFF;
        if (replicate) return (d & mask) * ((order == 2'd0) ? 32'h0101_0101 : 32'h0001_0001);
        sh = (order == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        return (d & mask) << sh;
    endfunction

    // ---------------- observations from the driver ----------------
    logic        obs_ready, obs_stable, obs_busy_ok, obs_wb_seen, obs_wbb_seen;
    logic        obs_after_valid, obs_after_busy;
    int          obs_req_acc, obs_lat;
    logic [31:0] obs_ldst_addr, obs_ldst_data, obs_ldst_data_b, obs_ldst_tid, obs_ldst_pdt;
    logic [1:0]  obs_ldst_order, obs_ldst_mmumod;
    logic        obs_ldst_rw;
    logic        obs_wb_rw;
    logic [4:0]  obs_wb_dest;
    logic [1:0]  obs_wb_fault;
    logic [13:0] obs_wb_flags;
    logic [31:0] obs_wb_data, obs_wbb_data, obs_after_data;

    task automatic apply_reset();
        rst = 1'b1;
        exe_req = 1'b0; remove = 1'b0; ldst_busy = 1'b0; ldst_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drives one operation end-to-end; called and returned at posedge+1.
    task automatic run_op(input logic rw, input logic [1:0] order, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] dest, input int busy_cyc, input int resp_dly,
                          input logic pf, input logic [13:0] flags, input logic [31:0] rdata);
        int edges;
        obs_req_acc = 0; obs_stable = 1'b1; obs_busy_ok = 1'b1;
        obs_wb_seen = 1'b0; obs_wbb_seen = 1'b0; obs_lat = -1;
        obs_ready = !exe_busy;
        exe_rw = rw; exe_order = order; exe_signed = sgn; exe_addr = addr;
        exe_data = wdata; exe_dest = dest; exe_tid = 14'($urandom);
        exe_mmumod = 2'($urandom); exe_pdt = $urandom; exe_req = 1'b1;
        @(posedge clk); #1;
        exe_req = 1'b0; exe_data = $urandom; exe_addr = $urandom; edges = 1;
        if (ldst_req) begin
            obs_ldst_addr = ldst_addr; obs_ldst_data = ldst_data; obs_ldst_data_b = ldst_data_b;
            obs_ldst_tid = ldst_tid; obs_ldst_pdt = ldst_pdt; obs_ldst_order = ldst_order;
            obs_ldst_mmumod = ldst_mmumod; obs_ldst_rw = ldst_rw;
            for (int i = 0; i < busy_cyc; i++) begin
                ldst_busy = 1'b1; #1;
                if (!ldst_req || ldst_addr !== obs_ldst_addr || ldst_data !== obs_ldst_data ||
                    ldst_tid !== obs_ldst_tid || ldst_order !== obs_ldst_order) obs_stable = 1'b0;
                if (!exe_busy) obs_busy_ok = 1'b0;
                @(posedge clk); #1; edges++;
            end
            ldst_busy = 1'b0; #1;
            if (!ldst_req) obs_stable = 1'b0;
            else obs_req_acc++;
            @(posedge clk); #1; edges++;
            for (int i = 0; i < resp_dly; i++) begin
                if (ldst_req) obs_req_acc++;
                if (!exe_busy) obs_busy_ok = 1'b0;
                @(posedge clk); #1; edges++;
            end
            if (ldst_req) obs_req_acc++;
            ldst_valid = 1'b1; ldst_pf = pf; ldst_flags = flags; ldst_rdata = rdata;
            @(posedge clk); #1; edges++;
            ldst_valid = 1'b0; ldst_pf = 1'b0; ldst_flags = 14'($urandom); ldst_rdata = $urandom;
        end
        for (int i = 0; i < 8 && !obs_wb_seen; i++) begin
            #1;
            if (wb_valid_b) begin obs_wbb_seen = 1'b1; obs_wbb_data = wb_data_b; end
            if (wb_valid) begin
                obs_wb_seen = 1'b1; obs_lat = edges;
                obs_wb_rw = wb_rw; obs_wb_dest = wb_dest; obs_wb_fault = wb_fault;
                obs_wb_flags = wb_flags; obs_wb_data = wb_data;
            end else begin
                @(posedge clk); #1; edges++;
            end
        end
        @(posedge clk); #1;
        obs_after_valid = wb_valid; obs_after_busy = exe_busy; obs_after_data = wb_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++; if (exe_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", exe_busy); end
        n_vec++; if (ldst_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", ldst_req); end
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wbv: got %b want 0", wb_valid); end
        n_vec++; if (ldst_tid !== 32'h0 || ldst_addr !== 32'h0 || ldst_data !== 32'h0 || ldst_pdt !== 32'h0)
            begin n_err++; $display("FAIL reset_ldst: tid %h addr %h data %h pdt %h want 0", ldst_tid, ldst_addr, ldst_data, ldst_pdt); end
        n_vec++; if (wb_data !== 32'h0 || wb_fault !== 2'b00 || wb_flags !== 14'h0 || wb_dest !== 5'd0)
            begin n_err++; $display("FAIL reset_wb: data %h fault %b flags %h dest %0d want 0", wb_data, wb_fault, wb_flags, wb_dest); end
    endtask

    task automatic test_signed_byte_load();
        run_op(1'b1, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd7, 0, 0, 1'b0, 14'h0155, 32'h80FF_1234);
        n_vec++; if (obs_ldst_addr !== 32'h1003) begin n_err++; $display("FAIL sbyte_addr: got %h want 00001003", obs_ldst_addr); end
        n_vec++; if (obs_ldst_tid !== {18'h0, exe_tid}) begin n_err++; $display("FAIL sbyte_tid: got %h want %h", obs_ldst_tid, {18'h0, exe_tid}); end
        n_vec++; if (obs_ldst_pdt !== exe_pdt || obs_ldst_mmumod !== exe_mmumod || obs_ldst_rw !== 1'b1 || obs_ldst_order !== 2'd0)
            begin n_err++; $display("FAIL sbyte_fields: pdt %h mm %0d rw %b ord %0d", obs_ldst_pdt, obs_ldst_mmumod, obs_ldst_rw, obs_ldst_order); end
        n_vec++; if (!obs_wb_seen) begin n_err++; $display("FAIL sbyte_timeout: no writeback pulse"); end
        n_vec++; if (obs_wb_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sbyte_data: got %h want ffffff80", obs_wb_data); end
        n_vec++; if (obs_wb_fault !== 2'b00 || obs_wb_dest !== 5'd7 || obs_wb_flags !== 14'h0155)
            begin n_err++; $display("FAIL sbyte_wb: fault %b dest %0d flags %h want 00/7/0155", obs_wb_fault, obs_wb_dest, obs_wb_flags); end
        n_vec++; if (obs_lat !== 3) begin n_err++; $display("FAIL sbyte_latency: got %0d want 3", obs_lat); end
        n_vec++; if (obs_wbb_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sbyte_data_b: got %h want ffffff80", obs_wbb_data); end
    endtask

    task automatic test_half_store();
        run_op(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd3, 0, 1, 1'b0, 14'h2001, 32'hDEAD_BEEF);
        n_vec++; if (obs_ldst_data !== 32'hABCD_ABCD) begin n_err++; $display("FAIL hstore_rep: got %h want abcdabcd", obs_ldst_data); end
        n_vec++; if (obs_ldst_data_b !== 32'hABCD_0000) begin n_err++; $display("FAIL hstore_lane: got %h want abcd0000", obs_ldst_data_b); end
        n_vec++; if (!obs_wb_seen || obs_wb_rw !== 1'b0 || obs_wb_data !== 32'h0)
            begin n_err++; $display("FAIL hstore_wb: seen %b rw %b data %h want 1/0/0", obs_wb_seen, obs_wb_rw, obs_wb_data); end
        n_vec++; if (obs_wb_flags !== 14'h2001) begin n_err++; $display("FAIL hstore_flags: got %h want 2001", obs_wb_flags); end
    endtask

    task automatic test_back_pressure();
        run_op(1'b1, 2'd2, 1'b0, 32'h5004, 32'h0, 5'd9, 5, 0, 1'b0, 14'h0, 32'h1357_9BDF);
        n_vec++; if (!obs_stable) begin n_err++; $display("FAIL bp_stable: request dropped or fields changed while busy"); end
        n_vec++; if (!obs_busy_ok) begin n_err++; $display("FAIL bp_exe_busy: oEXE_BUSY fell during operation"); end
        n_vec++; if (obs_req_acc !== 1) begin n_err++; $display("FAIL bp_accepts: got %0d want 1", obs_req_acc); end
        n_vec++; if (obs_wb_data !== 32'h1357_9BDF) begin n_err++; $display("FAIL bp_data: got %h want 13579bdf", obs_wb_data); end
        n_vec++; if (obs_lat !== 8) begin n_err++; $display("FAIL bp_latency: got %0d want 8", obs_lat); end
    endtask

    task automatic test_pagefault();
        run_op(1'b1, 2'd2, 1'b1, 32'h6000, 32'h0, 5'd12, 0, 2, 1'b1, 14'h2A5A, 32'hFFFF_FFFF);
        n_vec++; if (obs_wb_fault !== 2'b01) begin n_err++; $display("FAIL pf_fault: got %b want 01", obs_wb_fault); end
        n_vec++; if (obs_wb_data !== 32'h0) begin n_err++; $display("FAIL pf_data: got %h want 0", obs_wb_data); end
        n_vec++; if (obs_wb_flags !== 14'h2A5A) begin n_err++; $display("FAIL pf_flags: got %h want 2a5a", obs_wb_flags); end
    endtask

    task automatic test_flush();
        int pulses;
        // flush while the request is still being back-pressured
        exe_rw = 1'b1; exe_order = 2'd2; exe_addr = 32'h7000; exe_req = 1'b1; ldst_busy = 1'b1;
        @(posedge clk); #1 exe_req = 1'b0; remove = 1'b1;
        @(posedge clk); #1 remove = 1'b0; ldst_busy = 1'b0; #1;
        n_vec++; if (exe_busy !== 1'b0 || ldst_req !== 1'b0)
            begin n_err++; $display("FAIL flush_issue: busy %b req %b want 0/0", exe_busy, ldst_req); end
        // flush in WAIT, response arrives 4 cycles later and must be absorbed
        exe_addr = 32'h7004; exe_req = 1'b1;
        @(posedge clk); #1 exe_req = 1'b0;
        @(posedge clk); #1 remove = 1'b1;
        @(posedge clk); #1 remove = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid) pulses++;
            n_vec++; if (exe_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b want 1 at cycle %0d", exe_busy, i); end
            @(posedge clk); #1;
        end
        ldst_valid = 1'b1; ldst_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1 ldst_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid) pulses++;
            @(posedge clk); #1;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL drain_wbv: got %0d pulses want 0", pulses); end
        n_vec++; if (exe_busy !== 1'b0) begin n_err++; $display("FAIL drain_idle: busy %b want 0", exe_busy); end
        run_op(1'b1, 2'd1, 1'b0, 32'h7006, 32'h0, 5'd21, 0, 0, 1'b0, 14'h0, 32'h8421_0000);
        n_vec++; if (!obs_wb_seen || obs_wb_data !== 32'h0000_8421 || obs_wb_dest !== 5'd21)
            begin n_err++; $display("FAIL drain_next: seen %b data %h dest %0d want 1/00008421/21", obs_wb_seen, obs_wb_data, obs_wb_dest); end
    endtask

    task automatic test_random();
        logic [1:0]  order;
        logic [31:0] addr, wdata, rdata, exp;
        logic        rw, sgn, pf;
        logic [13:0] flags;
        logic [4:0]  dest;
        int          bc, rd;
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom); sgn = 1'($urandom); order = 2'($urandom_range(0, 2));
            addr = $urandom;
            if (order == 2'd1) addr[0] = 1'b0;
            if (order == 2'd2) addr[1:0] = 2'b00;
            wdata = $urandom; rdata = $urandom; flags = 14'($urandom); dest = 5'($urandom);
            pf = ($urandom_range(0, 7) == 0); bc = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            run_op(rw, order, sgn, addr, wdata, dest, bc, rd, pf, flags, rdata);
            exp = (pf || !rw) ? 32'h0 : m_load(order, sgn, addr, rdata);
            n_vec++; if (!obs_ready) begin n_err++; $display("FAIL rnd%0d_ready: oEXE_BUSY high in idle", n); end
            n_vec++; if (obs_ldst_addr !== addr) begin n_err++; $display("FAIL rnd%0d_addr: got %h want %h", n, obs_ldst_addr, addr); end
            if (!rw) begin
                n_vec++; if (obs_ldst_data !== m_store(order, addr, wdata, 1'b1))
                    begin n_err++; $display("FAIL rnd%0d_sdata: got %h want %h", n, obs_ldst_data, m_store(order, addr, wdata, 1'b1)); end
                n_vec++; if (obs_ldst_data_b !== m_store(order, addr, wdata, 1'b0))
                    begin n_err++; $display("FAIL rnd%0d_sdata_b: got %h want %h", n, obs_ldst_data_b, m_store(order, addr, wdata, 1'b0)); end
            end
            n_vec++; if (obs_req_acc !== 1 || !obs_stable)
                begin n_err++; $display("FAIL rnd%0d_req: accepts %0d stable %b want 1/1", n, obs_req_acc, obs_stable); end
            n_vec++; if (obs_lat !== 3 + bc + rd) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, obs_lat, 3 + bc + rd); end
            n_vec++; if (obs_wb_data !== exp) begin n_err++; $display("FAIL rnd%0d_data: got %h want %h", n, obs_wb_data, exp); end
            n_vec++; if (!obs_wbb_seen || obs_wbb_data !== exp) begin n_err++; $display("FAIL rnd%0d_data_b: got %h want %h", n, obs_wbb_data, exp); end
            n_vec++; if (obs_wb_fault !== (pf ? 2'b01 : 2'b00) || obs_wb_flags !== flags || obs_wb_dest !== dest || obs_wb_rw !== rw)
                begin n_err++; $display("FAIL rnd%0d_wb: fault %b flags %h dest %0d rw %b want %b/%h/%0d/%b", n, obs_wb_fault, obs_wb_flags, obs_wb_dest, obs_wb_rw, (pf ? 2'b01 : 2'b00), flags, dest, rw); end
            n_vec++; if (obs_after_valid !== 1'b0 || obs_after_busy !== 1'b0 || obs_after_data !== exp)
                begin n_err++; $display("FAIL rnd%0d_after: wbv %b busy %b data %h want 0/0/%h", n, obs_after_valid, obs_after_busy, obs_after_data, exp); end
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd17, 0, 0, 1'b0, 14'h0, 32'h1111_2222);
        n_vec++; if (obs_req_acc !== 0) begin n_err++; $display("FAIL misal_req: got %0d requests want 0", obs_req_acc); end
        n_vec++; if (!obs_wb_seen || obs_lat > 2) begin n_err++; $display("FAIL misal_latency: seen %b lat %0d want <=2", obs_wb_seen, obs_lat); end
        n_vec++; if (obs_wb_fault !== 2'b10 || obs_wb_data !== 32'h0 || obs_wb_dest !== 5'd17 || obs_wb_rw !== 1'b1)
            begin n_err++; $display("FAIL misal_wb: fault %b data %h dest %0d rw %b want 10/0/17/1", obs_wb_fault, obs_wb_data, obs_wb_dest, obs_wb_rw); end
        apply_reset();
        run_op(1'b0, 2'd3, 1'b0, 32'h3000, 32'h55, 5'd2, 0, 0, 1'b0, 14'h0, 32'h0);
        n_vec++; if (obs_req_acc !== 0 || obs_wb_fault !== 2'b10 || !obs_wbb_seen)
            begin n_err++; $display("FAIL order3: reqs %0d fault %b seen_b %b want 0/10/1", obs_req_acc, obs_wb_fault, obs_wbb_seen); end
    endtask

    task automatic test_remove_resp();
        logic [31:0] prev;
        prev = wb_data;
        exe_rw = 1'b1; exe_order = 2'd3; exe_dest = 5'd30; exe_req = 1'b1;
        @(posedge clk); #1 exe_req = 1'b0; remove = 1'b1; #1;
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rmresp_wbv: got %b want 0", wb_valid); end
        n_vec++; if (wb_data !== prev || wb_dest !== 5'd2) begin n_err++; $display("FAIL rmresp_hold: data %h dest %0d want %h/2", wb_data, wb_dest, prev); end
        @(posedge clk); #1 remove = 1'b0; #1;
        n_vec++; if (exe_busy !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL rmresp_idle: busy %b wbv %b want 0/0", exe_busy, wb_valid); end
    endtask

    task automatic test_reset_mid();
        exe_rw = 1'b1; exe_order = 2'd2; exe_addr = 32'h9000; exe_tid = 14'h3FFF; exe_req = 1'b1; ldst_busy = 1'b1;
        @(posedge clk); #1 exe_req = 1'b0;
        rst = 1'b1; #1;
        n_vec++; if (exe_busy !== 1'b0 || ldst_req !== 1'b0 || ldst_tid !== 32'h0 || ldst_addr !== 32'h0)
            begin n_err++; $display("FAIL reset_mid: busy %b req %b tid %h addr %h want 0", exe_busy, ldst_req, ldst_tid, ldst_addr); end
        ldst_busy = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b1, 2'd0, 1'b0, 32'h9001, 32'h0, 5'd4, 0, 0, 1'b0, 14'h0, 32'h0000_C300);
        n_vec++; if (obs_wb_data !== 32'h0000_00C3) begin n_err++; $display("FAIL reset_recover: got %h want 000000c3", obs_wb_data); end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_signed_byte_load();
        test_half_store();
        test_back_pressure();
        test_pagefault();
        test_flush();
        test_random();
        test_misaligned();
        test_remove_resp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
